// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a 32-bit word stream into 512-bit blocks with 0x80, zero fill and bit length.
// Optional feature: define SHA1_PADDER_PROTO_CHECK_EN to flag bad byte counts on err_o.
`timescale 1ns/1ps

module sha1_padder #(
  parameter int BlockWidth = 512,
  parameter int WordSize   = 32,
  parameter int LenWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [WordSize-1:0]   data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic                  data_last_i,
  input  logic [2:0]            data_bytes_i,
  output logic [BlockWidth-1:0] block_o,
  output logic                  block_valid_o,
  input  logic                  block_ready_i,
  output logic                  block_last_o,
  output logic                  err_o
);

  localparam int NumWords    = BlockWidth / WordSize;
  localparam int LastDataIdx = NumWords - LenWidth / WordSize - 1;
  localparam int CntWidth    = LenWidth - 3;
  localparam int LsbWidth    = $clog2(BlockWidth);
  localparam logic [WordSize-1:0] PadWord = {1'b1, {(WordSize-1){1'b0}}};

  typedef enum logic [1:0] {StFill, StPad, StLen, StOut} state_e;

  state_e                state_q, state_d;
  logic [BlockWidth-1:0] blk_q, blk_d;
  logic [3:0]            idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  extra_q, extra_d;
  logic                  pad_pend_q, pad_pend_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic [2:0]            eff_bytes;
  logic                  proto_err;
  logic [WordSize-1:0]   tail_word;
  logic [LsbWidth-1:0]   wr_lsb;
  logic                  at_last_idx;
  logic                  len_fits;

`ifdef SHA1_PADDER_PROTO_CHECK_EN
  assign proto_err = (data_bytes_i > 3'd4) || (!data_last_i && (data_bytes_i != 3'd4));
  assign eff_bytes = proto_err ? 3'd4 : data_bytes_i;
`else
  assign proto_err = 1'b0;
  assign eff_bytes = (data_bytes_i > 3'd4) ? 3'd4 : data_bytes_i;
`endif

  // Partial tail word: keep the valid bytes, append 0x80 right after them.
  assign tail_word = (data_i & ~({WordSize{1'b1}} >> {eff_bytes, 3'b000}))
                   | (PadWord >> {eff_bytes, 3'b000});

  assign wr_lsb      = LsbWidth'((NumWords - 1 - int'(idx_q)) * WordSize);
  assign at_last_idx = (idx_q == 4'(NumWords - 1));
  assign len_fits    = (idx_q <= 4'(LastDataIdx));

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    extra_d    = extra_q;
    pad_pend_d = pad_pend_q;
    last_d     = last_q;
    err_d      = 1'b0;

    if (clear_i) begin
      state_d    = StFill;
      blk_d      = '0;
      idx_d      = '0;
      cnt_d      = '0;
      extra_d    = 1'b0;
      pad_pend_d = 1'b0;
      last_d     = 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (data_valid_i) begin
            err_d = proto_err;
            cnt_d = cnt_q + CntWidth'(eff_bytes);
            if (!data_last_i || (eff_bytes == 3'd4)) begin
              blk_d[wr_lsb +: WordSize] = data_i;
              if (at_last_idx) begin
                state_d    = StOut;
                pad_pend_d = data_last_i;
              end else begin
                idx_d = idx_q + 4'd1;
                if (data_last_i) state_d = StPad;
              end
            end else if (eff_bytes == 3'd0) begin
              state_d = StPad;
            end else begin
              blk_d[wr_lsb +: WordSize] = tail_word;
              if (len_fits) begin
                state_d = StLen;
              end else begin
                state_d = StOut;
                extra_d = 1'b1;
              end
            end
          end
        end
        StPad: begin
          blk_d[wr_lsb +: WordSize] = PadWord;
          if (len_fits) begin
            state_d = StLen;
          end else begin
            state_d = StOut;
            extra_d = 1'b1;
          end
        end
        StLen: begin
          blk_d[LenWidth-1:0] = {cnt_q, 3'b000};
          last_d  = 1'b1;
          state_d = StOut;
        end
        StOut: begin
          if (block_ready_i) begin
            blk_d = '0;
            idx_d = '0;
            if (pad_pend_q) begin
              state_d    = StPad;
              pad_pend_d = 1'b0;
            end else if (extra_q) begin
              state_d = StLen;
              extra_d = 1'b0;
            end else begin
              state_d = StFill;
            end
            if (last_q) begin
              cnt_d      = '0;
              extra_d    = 1'b0;
              pad_pend_d = 1'b0;
              last_d     = 1'b0;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StFill;
      blk_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      extra_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      extra_q    <= extra_d;
      pad_pend_q <= pad_pend_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  assign data_ready_o  = (state_q == StFill);
  assign block_valid_o = (state_q == StOut);
  assign block_last_o  = (state_q == StOut) && last_q;
  assign block_o       = blk_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Directed self-checking bench for sha1_padder with hand-computed padded blocks.
`timescale 1ns/1ps

module tb_sha1_padder;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic [31:0]  data_i = '0;
  logic         data_valid_i = 1'b0;
  logic         data_ready_o;
  logic         data_last_i = 1'b0;
  logic [2:0]   data_bytes_i = '0;
  logic [511:0] block_o;
  logic         block_valid_o;
  logic         block_ready_i = 1'b0;
  logic         block_last_o;
  logic         err_o;

  int total = 0;
  int bad = 0;
  int errCycles = 0;
  int errAll = 0;
  int lat;
  logic [31:0] expWords [16];

  sha1_padder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_last_i  (data_last_i),
    .data_bytes_i (data_bytes_i),
    .block_o      (block_o),
    .block_valid_o(block_valid_o),
    .block_ready_i(block_ready_i),
    .block_last_o (block_last_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (err_o === 1'b1) begin
      errCycles++;
      errAll++;
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] packExp();
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[(15-i)*32 +: 32] = expWords[i];
    return b;
  endfunction

  task automatic clearExp();
    for (int i = 0; i < 16; i++) expWords[i] = '0;
  endtask

  // One word per call; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] data, input logic last, input logic [2:0] bytes);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk_i);
    while (data_ready_o !== 1'b1 && waitCnt < 50) begin
      @(negedge clk_i);
      waitCnt++;
    end
    if (data_ready_o !== 1'b1) checkOutput("ready_timeout", 512'(data_ready_o), 512'(1));
    data_i = data;
    data_valid_i = 1'b1;
    data_last_i = last;
    data_bytes_i = bytes;
    @(posedge clk_i);
    #1;
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
    data_bytes_i = '0;
  endtask

  task automatic waitBlock(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_i);
      cycles++;
    end while (block_valid_o !== 1'b1 && cycles < 20);
    if (block_valid_o !== 1'b1) checkOutput("block_timeout", 512'(block_valid_o), 512'(1));
  endtask

  task automatic takeBlock();
    block_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    block_ready_i = 1'b0;
  endtask

  task automatic runAbc(input string tag);
    applyStimulus(32'h61626300, 1'b1, 3'd3);
    waitBlock(lat);
    checkOutput({tag, "_latency"}, 512'(lat), 512'(2));
    clearExp();
    expWords[0] = 32'h61626380;
    expWords[15] = 32'h00000018;
    checkOutput({tag, "_block"}, block_o, packExp());
    checkOutput({tag, "_last"}, 512'(block_last_o), 512'(1));
    takeBlock();
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_i);
    checkOutput("rst_ready", 512'(data_ready_o), 512'(1));
    checkOutput("rst_valid", 512'(block_valid_o), 512'(0));
    checkOutput("rst_last", 512'(block_last_o), 512'(0));
    checkOutput("rst_block", block_o, 512'(0));
    checkOutput("rst_err", 512'(err_o), 512'(0));
    rst_ni = 1'b1;

    // "abc"
    runAbc("abc");
    @(negedge clk_i);
    checkOutput("abc_refill_ready", 512'(data_ready_o), 512'(1));

    // Empty message: data must not be written
    applyStimulus(32'hDEADBEEF, 1'b1, 3'd0);
    waitBlock(lat);
    checkOutput("empty_latency", 512'(lat), 512'(3));
    clearExp();
    expWords[0] = 32'h80000000;
    checkOutput("empty_block", block_o, packExp());
    checkOutput("empty_last", 512'(block_last_o), 512'(1));
    takeBlock();

    // 56 bytes: padding spills into an extra length-only block
    for (int i = 0; i < 14; i++) applyStimulus(32'hA5000000 + 32'(i), (i == 13), 3'd4);
    waitBlock(lat);
    clearExp();
    for (int i = 0; i < 14; i++) expWords[i] = 32'hA5000000 + 32'(i);
    expWords[14] = 32'h80000000;
    checkOutput("b56_blk1", block_o, packExp());
    checkOutput("b56_blk1_last", 512'(block_last_o), 512'(0));
    takeBlock();
    waitBlock(lat);
    checkOutput("b56_blk2_latency", 512'(lat), 512'(2));
    clearExp();
    expWords[15] = 32'h000001C0;
    checkOutput("b56_blk2", block_o, packExp());
    checkOutput("b56_blk2_last", 512'(block_last_o), 512'(1));
    takeBlock();

    // 64 bytes with backpressure on the data block
    for (int i = 0; i < 16; i++) applyStimulus(32'h3C000000 + 32'(i), (i == 15), 3'd4);
    waitBlock(lat);
    clearExp();
    for (int i = 0; i < 16; i++) expWords[i] = 32'h3C000000 + 32'(i);
    for (int c = 0; c < 5; c++) begin
      checkOutput("b64_hold_block", block_o, packExp());
      checkOutput("b64_hold_ready", 512'(data_ready_o), 512'(0));
      @(negedge clk_i);
    end
    checkOutput("b64_blk1_last", 512'(block_last_o), 512'(0));
    takeBlock();
    waitBlock(lat);
    checkOutput("b64_blk2_latency", 512'(lat), 512'(3));
    clearExp();
    expWords[0] = 32'h80000000;
    expWords[15] = 32'h00000200;
    checkOutput("b64_blk2", block_o, packExp());
    checkOutput("b64_blk2_last", 512'(block_last_o), 512'(1));
    takeBlock();

    // Clear after 5 words, with a word offered on the clear cycle
    for (int i = 0; i < 5; i++) applyStimulus(32'h77000000 + 32'(i), 1'b0, 3'd4);
    @(negedge clk_i);
    clear_i = 1'b1;
    data_i = 32'hFFFFFFFF;
    data_valid_i = 1'b1;
    data_bytes_i = 3'd4;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    data_valid_i = 1'b0;
    data_bytes_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("clr_no_block", 512'(block_valid_o), 512'(0));
    runAbc("clr_abc");

    // Protocol error: non-last word claiming 2 bytes
    errCycles = 0;
    applyStimulus(32'hAABBCCDD, 1'b0, 3'd2);
    applyStimulus(32'h61626300, 1'b1, 3'd3);
    waitBlock(lat);
    clearExp();
    expWords[0] = 32'hAABBCCDD;
    expWords[1] = 32'h61626380;
`ifdef SHA1_PADDER_PROTO_CHECK_EN
    expWords[15] = 32'h00000038;
    checkOutput("err_pulses", 512'(errCycles), 512'(1));
`else
    expWords[15] = 32'h00000028;
    checkOutput("err_pulses", 512'(errCycles), 512'(0));
`endif
    checkOutput("err_block", block_o, packExp());
    takeBlock();
    repeat (2) @(negedge clk_i);
`ifdef SHA1_PADDER_PROTO_CHECK_EN
    checkOutput("err_all", 512'(errAll), 512'(1));
`else
    checkOutput("err_all", 512'(errAll), 512'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha1_padder.md
# sha1_padder

Message pre-processor feeding the SHA-1 core's 512-bit block interface. Accepts a big-endian 32-bit word stream with a last marker and byte count. Emits SHA-1-padded 512-bit blocks over a valid/ready handshake: the `0x80` terminator, zero fill, and the 64-bit big-endian bit length. Inserts the extra block when the padding does not fit.

## Interface

**Parameters**
- `BlockWidth`, default 512: output block width.
- `WordSize`, default 32: input word width.
- `LenWidth`, default 64: message length field width in bits; occupies words 14–15.

**Ports** (clock and reset first)
- `clk_i`: input, 1 bit. Clock.
- `rst_ni`: input, 1 bit. Reset, asynchronous, active-low.
- `clear_i`: input, 1 bit. Synchronous abort of the current message.
- `data_i`: input, 32 bits. Message word; byte 0 at [31:24].
- `data_valid_i`: input, 1 bit. Word valid.
- `data_ready_o`: output, 1 bit. Word accepted when valid & ready.
- `data_last_i`: input, 1 bit. Final word of the message.
- `data_bytes_i`: input, 3 bits. Valid bytes, MSB-aligned. Must be 4 when not last; 0..4 when last. 0 denotes an empty tail.
- `block_o`: output, 512 bits. Block; word 0 at [511:480].
- `block_valid_o`: output, 1 bit. Block valid.
- `block_ready_i`: input, 1 bit. Consumer accepts the block.
- `block_last_o`: output, 1 bit. Block is the final block of the message.
- `err_o`: output, 1 bit. Protocol error pulse (see Configuration).

## Operation

- **Registers:** block register (512 bits), word index `idx` (4 bits), byte counter (`LenWidth`-3 bits, wraps modulo 2^61), flags `extra`, `pad_pend`, `last`.
- **FILL** (`data_ready_o`=1):
  - Each accepted word is written at `idx` and the byte counter advances by `data_bytes_i`.
  - Non-last word at idx<15: `idx`++.
  - Non-last word at idx 15: go to OUT with `last`=0.
  - Last word, bytes 1..3: write the data bytes, put `0x80` in byte position `bytes`, zero the rest. If idx≤13, go to LEN; otherwise go to OUT with `extra`=1.
  - Last word, bytes=4: write the word. If idx<15, `idx`++ and go to PAD. If idx=15, go to OUT with `pad_pend`=1.
  - Last word, bytes=0: nothing is written; go to PAD.
- **PAD** (1 cycle): write `0x80000000` at `idx`. If idx≤13, go to LEN; otherwise go to OUT with `extra`=1.
- **LEN** (1 cycle): write word 14 = bit length [63:32] and word 15 = bit length [31:0], where bit length = bytes×8. Go to OUT with `last`=1.
- **OUT:**
  - `block_valid_o`=1; `block_o` and `block_last_o` are held stable until `block_ready_i`.
  - On the handshake: block register cleared to zero, `idx`=0.
  - Next state: PAD if `pad_pend`; else LEN if `extra`; else FILL.
  - If `last`, the byte counter is reset and all flags are cleared.
- **Unused words** are zero, because the block register is cleared on every handshake.
- **clear_i** has priority over everything: state goes to FILL, all registers are zeroed, and any word offered that cycle is discarded. A block handshake coinciding with `clear_i` is ignored by the padder.
- **Reset:** state FILL, block register 0, counters 0, flags 0.

## Timing

- **Output values:**
  - During reset: `data_ready_o`=1, `block_valid_o`=0, `block_last_o`=0, `block_o`=0, `err_o`=0.
  - `data_ready_o` and `block_valid_o` are decoded from the state register only; there is no combinational path from any input.
- **Throughput:** one word per cycle in FILL; a full 16-word data block reaches OUT on the cycle after the 16th word.
- **Latency:**
  - Last word with bytes 1..3 at idx≤13: `block_valid_o` rises 2 cycles after acceptance (LEN, then OUT).
  - Last word with bytes 0/4: 3 cycles (PAD, LEN, OUT).
- **Extra block:** OUT → LEN → OUT, so a second `block_valid_o` rises 2 cycles after the first handshake.
- **Back-to-back messages:** FILL is re-entered the cycle after the final handshake.

## Configuration

- `SHA1_PADDER_PROTO_CHECK_EN`
  - **Defined:** `err_o` pulses for 1 cycle when an accepted word has `data_bytes_i`>4, or is non-last with `data_bytes_i`≠4. The word is then treated as bytes=4; state is unaffected.
  - **Undefined:** `err_o` is tied to 0, and `data_bytes_i` values above 4 are interpreted as 4.

## Test plan

- **"abc":** one word `0x61626300`, last, bytes=3 → one block: word0=`0x61626380`, words 1–14=0, word15=`0x00000018`; `block_last_o`=1; valid 2 cycles after acceptance.
- **Empty message:** bytes=0, last at idx 0 → word0=`0x80000000`, all other words 0, length 0; `block_last_o`=1.
- **56-byte message** (14 words, last bytes=4) → block 1: words 0–13 data, word14=`0x80000000`, word15=0, `block_last_o`=0. Block 2: all zero except word15=`0x000001C0`, `block_last_o`=1.
- **64-byte message** (16 words, last bytes=4) → block 1 is pure data with `block_last_o`=0. Block 2: word0=`0x80000000`, word15=`0x00000200`, `block_last_o`=1.
- **Backpressure and clear:**
  - `block_ready_i` held low for 5 cycles: `block_o` stays stable and `data_ready_o`=0; after the handshake, FILL resumes with idx 0.
  - `clear_i` asserted after 5 words: no block is emitted; a following "abc" message produces the exact "abc" block above.
- **Error check:** with the macro defined, a non-last word with bytes=2 gives a 1-cycle `err_o` pulse and the word is processed as 4 bytes. With the macro undefined, `err_o` stays 0 throughout.
